// File: rtl/sync_s2f_simple.sv
`default_nettype none
// ============================================================================
// Module      : sync_s2f_simple
// Description : Slow-to-fast clock-domain crossing for a data word plus a
//               "set" strobe. The strobe is synchronised into fast_clk. Its
//               rising edge captures slow_data into fast_data and produces a
//               single-cycle fast_data_set pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_s2f_simple #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  fast_clk,
  input  logic                  fast_rst,
  input  logic [DATA_WIDTH-1:0] slow_data,
  input  logic                  slow_data_set,
  output logic [DATA_WIDTH-1:0] fast_data,
  output logic                  fast_data_set
);

  // Synchroniser chain: r_sync[0] is the metastability-catching flop and
  // r_sync[SYNC_STAGES-1] is the first stable copy. Nothing but wiring
  // is allowed between these flops.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [SYNC_STAGES-1:0] r_sync;

  // History of the synchronised strobe, used only for rising-edge detection.
  logic                   r_hist;

  // Rising edge of the synchronised strobe; a held-high strobe only yields
  // one edge, and a falling edge yields none.
  logic                   w_edge;

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

  // Shift the strobe through the synchroniser and record its last value.
  always_ff @(posedge fast_clk) begin
    if (!fast_rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], slow_data_set};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // Capture the (source-held stable) data word on the edge cycle and flag it.
  always_ff @(posedge fast_clk) begin
    if (!fast_rst) begin
      fast_data     <= '0;
      fast_data_set <= 1'b0;
    end else begin
      fast_data_set <= w_edge;
      if (w_edge) begin
        fast_data <= slow_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_s2f_simple.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_s2f_simple
// Description : Directed self-checking bench for sync_s2f_simple.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_s2f_simple;

  localparam int C_DW = 16;

  logic            fast_clk;
  logic            slow_clk;
  logic            fast_rst;
  logic [C_DW-1:0] slow_data;
  logic            slow_data_set;
  logic [C_DW-1:0] fast_data;
  logic            fast_data_set;

  int err_cnt;
  int chk_cnt;
  int pulse_cnt;
  int base_cnt;
  logic            prev_set;
  logic [C_DW-1:0] exp_q[$];
  logic [C_DW-1:0] rnd;

  sync_s2f_simple #(
    .DATA_WIDTH (C_DW),
    .SYNC_STAGES(2)
  ) dut (
    .fast_clk     (fast_clk),
    .fast_rst     (fast_rst),
    .slow_data    (slow_data),
    .slow_data_set(slow_data_set),
    .fast_data    (fast_data),
    .fast_data_set(fast_data_set)
  );

  // 20 ns fast clock, 82 ns unrelated slow clock
  initial fast_clk = 1'b0;
  always #10 fast_clk = ~fast_clk;
  initial slow_clk = 1'b0;
  always #41 slow_clk = ~slow_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n fast edges and land 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge fast_clk);
      #1;
    end
  endtask

  // Every pulse must be one cycle wide and carry the next expected word
  initial prev_set = 1'b0;
  always @(posedge fast_clk) begin
    #1;
    if (fast_data_set === 1'b1) begin
      pulse_cnt++;
      check("pulse_width", {31'd0, prev_set}, 32'd0);
      if (exp_q.size() == 0)
        check("unexpected_pulse", {31'd0, fast_data_set}, 32'd0);
      else
        check("pulse_data", {16'd0, fast_data}, {16'd0, exp_q.pop_front()});
    end
    prev_set = (fast_data_set === 1'b1);
  end

  initial begin
    err_cnt       = 0;
    chk_cnt       = 0;
    pulse_cnt     = 0;
    fast_rst      = 1'b0;
    slow_data     = '0;
    slow_data_set = 1'b0;

    // Reset held for 3 fast cycles
    tick(3);
    check("rst_data", {16'd0, fast_data}, 32'd0);
    check("rst_set", {31'd0, fast_data_set}, 32'd0);
    fast_rst = 1'b1;
    tick(2);

    // Single write: strobe sampled at edge E0, pulse seen after E2
    base_cnt      = pulse_cnt;
    slow_data     = 16'hA5C3;
    slow_data_set = 1'b1;
    exp_q.push_back(16'hA5C3);
    tick(1);
    check("single_e0", {31'd0, fast_data_set}, 32'd0);
    tick(1);
    check("single_e1", {31'd0, fast_data_set}, 32'd0);
    tick(1);
    check("single_e2_set", {31'd0, fast_data_set}, 32'd1);
    check("single_e2_data", {16'd0, fast_data}, 32'h0000A5C3);
    tick(1);
    slow_data_set = 1'b0;
    check("single_e3_set", {31'd0, fast_data_set}, 32'd0);
    check("single_e3_data", {16'd0, fast_data}, 32'h0000A5C3);
    tick(6);
    check("single_count", pulse_cnt - base_cnt, 32'd1);

    // 10 back-to-back random writes driven from the slow clock
    base_cnt = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge slow_clk);
      rnd           = C_DW'($urandom);
      slow_data     = rnd;
      slow_data_set = 1'b1;
      exp_q.push_back(rnd);
      @(posedge slow_clk);
      slow_data_set = 1'b0;
      @(posedge slow_clk);
    end
    tick(10);
    check("rand_count", pulse_cnt - base_cnt, 32'd10);
    check("rand_queue_empty", exp_q.size(), 32'd0);

    // Long strobe: 5 slow cycles high, one pulse only
    base_cnt = pulse_cnt;
    @(posedge slow_clk);
    slow_data     = 16'h1234;
    slow_data_set = 1'b1;
    exp_q.push_back(16'h1234);
    repeat (5) @(posedge slow_clk);
    slow_data_set = 1'b0;
    tick(10);
    check("long_count", pulse_cnt - base_cnt, 32'd1);
    check("long_data", {16'd0, fast_data}, 32'h00001234);

    // Strobe already high while in reset: one pulse after release
    tick(1);
    base_cnt      = pulse_cnt;
    fast_rst      = 1'b0;
    slow_data     = 16'hBEEF;
    slow_data_set = 1'b1;
    tick(3);
    check("rsthigh_data", {16'd0, fast_data}, 32'd0);
    check("rsthigh_set", {31'd0, fast_data_set}, 32'd0);
    exp_q.push_back(16'hBEEF);
    fast_rst = 1'b1;
    tick(6);
    check("rsthigh_count", pulse_cnt - base_cnt, 32'd1);
    check("rsthigh_value", {16'd0, fast_data}, 32'h0000BEEF);
    slow_data_set = 1'b0;
    tick(5);

    // Reset one cycle after the strobe was sampled: transfer discarded
    base_cnt      = pulse_cnt;
    slow_data     = 16'h7777;
    slow_data_set = 1'b1;
    tick(1);
    fast_rst = 1'b0;
    tick(1);
    slow_data_set = 1'b0;
    tick(2);
    check("midrst_data", {16'd0, fast_data}, 32'd0);
    check("midrst_set", {31'd0, fast_data_set}, 32'd0);
    fast_rst = 1'b1;
    tick(6);
    check("midrst_count", pulse_cnt - base_cnt, 32'd0);
    check("midrst_final_data", {16'd0, fast_data}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
